// File: rtl/event_serializer_pkg.sv
// Shared helpers for the event serializer slice.
package event_serializer_pkg;

    // Round-robin successor of a granted index, wrapping at the source count.
    function automatic int unsigned rr_next(input int unsigned grant, input int unsigned count);
        return (grant == count - 1) ? 0 : grant + 1;
    endfunction

endpackage

// File: rtl/event_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr, else lowest overall.
module event_rr_arbiter #(
    parameter int unsigned COUNT      = 16,
    parameter int unsigned COUNT_BITS = 4
) (
    input  logic [COUNT-1:0]      req,
    input  logic [COUNT_BITS-1:0] ptr,
    output logic [COUNT_BITS-1:0] grant,
    output logic                  any
);

    logic [COUNT-1:0]   mask;
    logic [2*COUNT-1:0] dbl;
    logic               found;

    // Lower half holds requests at or above ptr, upper half the unmasked wrap-around copy.
    always_comb begin
        mask  = '0;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < COUNT; i++) begin
            mask[i] = (COUNT_BITS'(i) >= ptr);
        end
        dbl = {req, req & mask};
        for (int unsigned i = 0; i < 2 * COUNT; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                grant = (i >= COUNT) ? COUNT_BITS'(i - COUNT) : COUNT_BITS'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/event_serializer.sv
// Collects per-source event pulses and emits them as a round-robin stream of event numbers.
module event_serializer
    import event_serializer_pkg::*;
#(
    parameter int unsigned COUNT      = 16,
    parameter int unsigned COUNT_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COUNT-1:0]      sn_event_valid,
    output logic [COUNT-1:0]      sn_event_ready,
    output logic [COUNT_BITS-1:0] m_evno_data,
    output logic                  m_evno_valid,
    input  logic                  m_evno_ready
);

    if ((COUNT < 2) || (COUNT > (1 << COUNT_BITS))) begin : g_param_check
        $error("event_serializer: COUNT must be in 2..2**COUNT_BITS");
    end

    logic [COUNT-1:0]      pending;
    logic [COUNT-1:0]      pending_next;
    logic [COUNT-1:0]      grant_onehot;
    logic [COUNT_BITS-1:0] ptr;
    logic [COUNT_BITS-1:0] grant;
    logic                  any;
    logic                  load;

    event_rr_arbiter #(
        .COUNT      (COUNT),
        .COUNT_BITS (COUNT_BITS)
    ) u_arb (
        .req   (pending),
        .ptr   (ptr),
        .grant (grant),
        .any   (any)
    );

    assign sn_event_ready = ~pending;
    assign load           = ~m_evno_valid | m_evno_ready;

    // Captures and the grant clear never collide: a pending source is not ready.
    always_comb begin
        grant_onehot = '0;
        for (int unsigned i = 0; i < COUNT; i++) begin
            grant_onehot[i] = (COUNT_BITS'(i) == grant);
        end
        pending_next = pending | (sn_event_valid & ~pending);
        if (load && any) begin
            pending_next = pending_next & ~grant_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            ptr          <= '0;
            m_evno_valid <= 1'b0;
            m_evno_data  <= '0;
        end else begin
            pending <= pending_next;
            if (load) begin
                if (any) begin
                    m_evno_valid <= 1'b1;
                    m_evno_data  <= grant;
                    ptr          <= COUNT_BITS'(rr_next(32'(grant), COUNT));
                end else begin
                    m_evno_valid <= 1'b0;
                end
            end
        end
    end

endmodule
